// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential accumulator ALU: opcodes, FSM states,
// flag bit positions and a helper that assembles the flag nibble.
package seq_alu_pkg;

   localparam logic [3:0] OP_PASS = 4'd0;
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_OR   = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd4;
   localparam logic [3:0] OP_SUB  = 4'd5;
   localparam logic [3:0] OP_SHL1 = 4'd6;
   localparam logic [3:0] OP_SHR1 = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_CLR  = 4'd9;

   localparam int FLAG_Z   = 0;
   localparam int FLAG_C   = 1;
   localparam int FLAG_N   = 2;
   localparam int FLAG_ERR = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Places the four flag bits at their architectural positions.
   function automatic logic [3:0] pack_flags(input logic err, input logic carry,
                                             input logic neg, input logic zero);
      logic [3:0] f;
      f           = '0;
      f[FLAG_ERR] = err;
      f[FLAG_N]   = neg;
      f[FLAG_C]   = carry;
      f[FLAG_Z]   = zero;
      return f;
   endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: consumes one multiplier bit per cycle and
// takes exactly WIDTH busy cycles regardless of operand values. The product
// output already includes the current step, so it is complete while done=1.
module seq_alu_mul
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic                 busy_q, busy_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [2*WIDTH-1:0]   prod_sum;

   // Partial product plus this cycle's conditional addend.
   always_comb begin
      prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
   end

   // Load operands on start, otherwise advance one multiplier bit per busy cycle.
   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      if (start) begin
         busy_d   = 1'b1;
         cnt_d    = CW'(WIDTH);
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         prod_d   = '0;
      end else if (busy_q) begin
         prod_d   = prod_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
         end
      end
   end

   // Multiplier state registers, cleared by reset so an aborted multiply leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q && (cnt_q == CW'(1));
   assign product = prod_sum;

endmodule

// File: rtl/seq_alu_core.sv
// Sequential accumulator ALU: accepts one command in IDLE, applies single-cycle
// ops immediately or runs the iterative multiplier, then presents the result in
// RESP until the consumer takes it.
module seq_alu_core
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_acc,
   output logic [3:0]       out_flags
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [3:0]           flags_q, flags_d;

   logic                 accept;
   logic                 is_mul;
   logic                 mul_start;
   logic                 mul_busy;
   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_product;

   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c;
   logic                 alu_err;
   logic [WIDTH:0]       sum_ext;
   logic [WIDTH:0]       diff_ext;

   assign accept    = in_valid && in_ready;
   assign is_mul    = (in_op == OP_MUL);
   assign mul_start = accept && is_mul && !mul_busy;

   seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (acc_q),
      .b       (in_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle ALU; the borrow of the extended subtraction is exactly acc < B.
   always_comb begin
      sum_ext  = {1'b0, acc_q} + {1'b0, in_b};
      diff_ext = {1'b0, acc_q} - {1'b0, in_b};
      alu_res  = acc_q;
      alu_c    = 1'b0;
      alu_err  = 1'b0;
      case (in_op)
         OP_PASS: alu_res = in_b;
         OP_AND:  alu_res = acc_q & in_b;
         OP_OR:   alu_res = acc_q | in_b;
         OP_XOR:  alu_res = acc_q ^ in_b;
         OP_ADD: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
         end
         OP_SUB: begin
            alu_res = diff_ext[WIDTH-1:0];
            alu_c   = diff_ext[WIDTH];
         end
         OP_SHL1: begin
            alu_res = {acc_q[WIDTH-2:0], 1'b0};
            alu_c   = acc_q[WIDTH-1];
         end
         OP_SHR1: begin
            alu_res = {1'b0, acc_q[WIDTH-1:1]};
            alu_c   = acc_q[0];
         end
         OP_MUL:  alu_res = acc_q;
         OP_CLR:  alu_res = '0;
         default: alu_err = 1'b1;
      endcase
   end

   // Next-state logic: multiply detours through MUL until the multiplier signals done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = is_mul ? ST_MUL : ST_RESP;
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Accumulator and flags change only at a non-MUL accept or at multiply completion.
   always_comb begin
      acc_d   = acc_q;
      flags_d = flags_q;
      if (accept && !is_mul) begin
         acc_d   = alu_res;
         flags_d = pack_flags(alu_err, alu_c, alu_res[WIDTH-1], (alu_res == '0));
      end else if ((state_q == ST_MUL) && mul_done) begin
         acc_d   = mul_product[WIDTH-1:0];
         flags_d = pack_flags(1'b0, |mul_product[2*WIDTH-1:WIDTH],
                              mul_product[WIDTH-1], (mul_product[WIDTH-1:0] == '0));
      end
   end

   // State, accumulator and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         flags_q <= flags_d;
      end
   end

   // Handshake outputs decoded purely from the current state.
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_RESP);
   end

   assign out_acc   = acc_q;
   assign out_flags = flags_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Self-checking bench for seq_alu_core: directed literal scenarios plus a
// randomized run checked every cycle against a transaction-level model.
module tb_seq_alu_core;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   in_op = 4'd0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_acc;
   logic [3:0]   out_flags;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model of the architectural state: accumulator/flags, remaining multiply
   // cycles, pending multiply result and whether a result is being presented.
   logic [W-1:0] m_acc = '0;
   logic [3:0]   m_flags = '0;
   logic [11:0]  m_pend = '0;
   int           m_cd = 0;
   bit           m_resp = 1'b0;

   seq_alu_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   // Result of one command from plain arithmetic; returns {ERR,N,C,Z, acc}.
   function automatic logic [11:0] model_op(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint ua, ub, r, mask;
      bit c, err;
      ua = longint'(a);
      ub = longint'(b);
      mask = (longint'(1) << W) - 1;
      c = 1'b0;
      err = 1'b0;
      r = ua;
      case (op)
         4'd0: r = ub;
         4'd1: r = ua & ub;
         4'd2: r = ua | ub;
         4'd3: r = ua ^ ub;
         4'd4: begin r = (ua + ub) & mask; c = ((ua + ub) > mask); end
         4'd5: begin r = (ua - ub + mask + 1) & mask; c = (ua < ub); end
         4'd6: begin r = (ua * 2) & mask; c = ((ua >> (W - 1)) & 1) != 0; end
         4'd7: begin r = ua / 2; c = (ua % 2) != 0; end
         4'd8: begin r = (ua * ub) & mask; c = ((ua * ub) >> W) != 0; end
         4'd9: r = 0;
         default: err = 1'b1;
      endcase
      return {err, ((r >> (W - 1)) & 1) != 0, c, (r == 0), r[W-1:0]};
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Transaction-level model update on each clock edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_acc   <= '0;
         m_flags <= '0;
         m_cd    <= 0;
         m_resp  <= 1'b0;
      end else if (m_resp) begin
         if (out_ready) m_resp <= 1'b0;
      end else if (m_cd > 0) begin
         m_cd <= m_cd - 1;
         if (m_cd == 1) begin
            {m_flags, m_acc} <= m_pend;
            m_resp <= 1'b1;
         end
      end else if (in_valid) begin
         if (in_op == 4'd8) begin
            m_pend <= model_op(in_op, m_acc, in_b);
            m_cd   <= W;
         end else begin
            {m_flags, m_acc} <= model_op(in_op, m_acc, in_b);
            m_resp <= 1'b1;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check_output("in_ready",  {31'd0, in_ready},  {31'd0, (!m_resp && m_cd == 0)});
         check_output("out_valid", {31'd0, out_valid}, {31'd0, m_resp});
         check_output("out_acc",   {24'd0, out_acc},   {24'd0, m_acc});
         check_output("out_flags", {28'd0, out_flags}, {28'd0, m_flags});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] b);
      in_valid = 1'b1;
      in_op    = op;
      in_b     = b;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 50) begin
         step();
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [3:0] op, input logic [W-1:0] b, output int lat,
                                 output logic [W-1:0] acc, output logic [3:0] flags);
      issue(op, b);
      wait_valid(lat);
      acc   = out_acc;
      flags = out_flags;
      release_result();
   endtask

   initial begin
      int lat;
      logic [W-1:0] acc;
      logic [3:0] flags;
      bit seen_valid;

      // Model self-pins from hand-computed values.
      check_output("model_mul", {20'd0, model_op(4'd8, 8'h12, 8'h34)}, 32'h6A8);
      check_output("model_sub", {20'd0, model_op(4'd5, 8'h00, 8'h01)}, 32'h6FF);
      check_output("model_ill", {20'd0, model_op(4'hB, 8'h80, 8'h55)}, 32'hC80);

      step();
      step();
      check_output("rst_ready", {31'd0, in_ready}, 32'd1);
      check_output("rst_valid", {31'd0, out_valid}, 32'd0);
      check_output("rst_acc", {24'd0, out_acc}, 32'h00);
      check_output("rst_flags", {28'd0, out_flags}, 32'h0);
      rst = 1'b0;
      chk_en = 1'b1;

      apply_stimulus(4'd0, 8'h0F, lat, acc, flags);
      check_output("pass_lat", lat, 1);
      check_output("pass_acc", {24'd0, acc}, 32'h0F);
      apply_stimulus(4'd1, 8'h3C, lat, acc, flags);
      check_output("and_lat", lat, 1);
      check_output("and_acc", {24'd0, acc}, 32'h0C);
      check_output("and_flags", {28'd0, flags}, 32'h0);

      // Stall in RESP with a competing command pending.
      issue(4'd4, 8'h04);
      in_valid = 1'b1;
      in_op    = 4'd9;
      in_b     = 8'h00;
      for (int i = 0; i < 5; i++) begin
         check_output("hold_valid", {31'd0, out_valid}, 32'd1);
         check_output("hold_ready", {31'd0, in_ready}, 32'd0);
         check_output("hold_acc", {24'd0, out_acc}, 32'h10);
         step();
      end
      in_valid = 1'b0;
      release_result();
      check_output("hold_after_acc", {24'd0, out_acc}, 32'h10);
      check_output("hold_after_ready", {31'd0, in_ready}, 32'd1);

      apply_stimulus(4'd0, 8'hFF, lat, acc, flags);
      apply_stimulus(4'd4, 8'h01, lat, acc, flags);
      check_output("add_acc", {24'd0, acc}, 32'h00);
      check_output("add_flags", {28'd0, flags}, 32'h3);
      apply_stimulus(4'd5, 8'h01, lat, acc, flags);
      check_output("sub_acc", {24'd0, acc}, 32'hFF);
      check_output("sub_flags", {28'd0, flags}, 32'h6);

      apply_stimulus(4'd0, 8'h12, lat, acc, flags);
      apply_stimulus(4'd8, 8'h34, lat, acc, flags);
      check_output("mul1_lat", lat, 9);
      check_output("mul1_acc", {24'd0, acc}, 32'hA8);
      check_output("mul1_flags", {28'd0, flags}, 32'h6);
      apply_stimulus(4'd0, 8'h03, lat, acc, flags);
      apply_stimulus(4'd8, 8'h05, lat, acc, flags);
      check_output("mul2_lat", lat, 9);
      check_output("mul2_acc", {24'd0, acc}, 32'h0F);
      check_output("mul2_flags", {28'd0, flags}, 32'h0);
      apply_stimulus(4'd8, 8'h00, lat, acc, flags);
      check_output("mul0_lat", lat, 9);
      check_output("mul0_flags", {28'd0, flags}, 32'h1);

      apply_stimulus(4'd0, 8'h80, lat, acc, flags);
      apply_stimulus(4'hB, 8'h55, lat, acc, flags);
      check_output("ill_lat", lat, 1);
      check_output("ill_acc", {24'd0, acc}, 32'h80);
      check_output("ill_flags", {28'd0, flags}, 32'hC);
      apply_stimulus(4'd0, 8'h01, lat, acc, flags);
      check_output("ill_clear_flags", {28'd0, flags}, 32'h0);

      // Reset in the middle of a multiply.
      apply_stimulus(4'd0, 8'h07, lat, acc, flags);
      issue(4'd8, 8'h03);
      step();
      step();
      step();
      rst = 1'b1;
      #1;
      check_output("abort_ready", {31'd0, in_ready}, 32'd1);
      check_output("abort_valid", {31'd0, out_valid}, 32'd0);
      check_output("abort_acc", {24'd0, out_acc}, 32'h00);
      check_output("abort_flags", {28'd0, out_flags}, 32'h0);
      step();
      rst = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid !== 1'b0) seen_valid = 1'b1;
         step();
      end
      check_output("abort_no_valid", {31'd0, seen_valid}, 32'd0);

      // Randomized traffic with occasional reset pulses.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 6);
         in_op     = 4'($urandom_range(0, 15));
         in_b      = 8'($urandom);
         out_ready = ($urandom_range(0, 1) == 1);
         rst       = ($urandom_range(0, 199) == 0);
         step();
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) step();
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_alu_core.md
SEQ_ALU_CORE -- requirements
Module: seq_alu_core

Interface
REQ-001 Parameter WIDTH, default 8, datapath/accumulator width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  command valid.
REQ-005 in_ready  output  1  core can accept command.
REQ-006 in_op  input  4  opcode.
REQ-007 in_b  input  WIDTH  operand B; operand A is the accumulator.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_acc  output  WIDTH  accumulator register, continuously driven.
REQ-011 out_flags  output  4  registered flags {ERR,N,C,Z}, bit3..bit0.

Function
REQ-012 FSM states SHALL be IDLE, MUL, RESP; in_ready = (state==IDLE), out_valid = (state==RESP), both decoded from state only.
REQ-013 Accept occurs on an edge where in_valid && in_ready; in_op/in_b are sampled only then.
REQ-014 Opcodes: 0 PASS (acc=B), 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB (acc-B), 6 SHL1, 7 SHR1 (logical, B ignored), 8 MUL, 9 CLR (acc=0); 10..15 illegal.
REQ-015 Non-MUL ops: acc and flags update at the accept edge; IDLE->RESP; out_valid high the cycle after accept.
REQ-016 MUL: IDLE->MUL at accept; iterative shift-add, one bit of B per cycle, exactly WIDTH cycles in MUL; then acc = low WIDTH bits of acc*B, flags update, MUL->RESP; out_valid high WIDTH+1 cycles after accept.
REQ-017 out_acc SHALL hold the pre-MUL accumulator value until the MUL completion edge.
REQ-018 RESP holds out_valid, out_acc, out_flags stable until out_ready; RESP->IDLE on the edge with out_ready high; no command accepted in RESP (max throughput one op per 2 cycles).
REQ-019 Z = (new acc == 0); N = new acc[WIDTH-1].
REQ-020 C: ADD carry-out; SUB 1 iff acc < B (unsigned borrow); SHL old acc[WIDTH-1]; SHR old acc[0]; MUL 1 iff upper WIDTH bits of the 2*WIDTH product nonzero; all others 0.
REQ-021 ADD/SUB/SHL SHALL wrap modulo 2^WIDTH.
REQ-022 Illegal opcode: acc unchanged, ERR=1, C=0, Z/N from unchanged acc, still goes IDLE->RESP; ERR=0 for every legal opcode.
REQ-023 MUL with B=0 or acc=0 SHALL still take WIDTH cycles.
REQ-024 in_valid asserted outside IDLE SHALL be ignored without side effects.

Reset
REQ-025 rst high SHALL immediately force state=IDLE, acc=0, out_flags=4'b0000, MUL counter/partial product=0; outputs in_ready=1, out_valid=0, out_acc=0.
REQ-026 rst during MUL or RESP SHALL abort the operation; no result is presented after reset release.
REQ-027 First accept is possible on the first rising edge with rst low.

Structure
REQ-028 Package seq_alu_pkg SHALL hold opcode constants, state encoding, and flag bit indices (FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_ERR=3).
REQ-029 Iterative multiplier SHALL be sub-module seq_alu_mul (start, operands, busy/done, 2*WIDTH product), cycle counter width $clog2(WIDTH+1).
REQ-030 Top-level SHALL contain FSM, accumulator, flag logic and single-cycle ALU.

Verification (WIDTH=8)
REQ-031 Reset, then PASS 0x0F, AND 0x3C -> acc=0x0C, flags=0000, out_valid one cycle after each accept.
REQ-032 PASS 0xFF, ADD 0x01 -> acc=0x00, Z=1, C=1; then SUB 0x01 -> acc=0xFF, C=1, N=1.
REQ-033 PASS 0x12, MUL 0x34 -> out_valid exactly 9 cycles after accept, acc=0xA8, C=1; PASS 0x03, MUL 0x05 -> acc=0x0F, C=0.
REQ-034 Hold out_ready low 5 cycles in RESP with in_valid high -> out_valid/out_acc stable, no new accept, in_ready=0.
REQ-035 opcode 0xB with acc=0x80 -> acc=0x80, flags ERR=1, N=1, C=0, Z=0; next legal op clears ERR.
REQ-036 Assert rst 4 cycles into MUL -> immediate IDLE, acc=0, flags=0000, no out_valid after release.
